calc_sequencer: RTL

- Command-issuing initiator that drives the calculator's register-file/ALU interface.
- Accepts packed instruction words over a valid/ready handshake and buffers them in a small FIFO.
- For each instruction it drives source address, immediate, ALU control and destination write, then reads the destination back.
- Returns the read-back value over a second valid/ready handshake; sits between a host/test driver and the calculator datapath.

---
 rtl/calc_sequencer_if.sv | 45 ++++
 rtl/calc_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// Handshake and datapath bundle between a host/calculator and calc_sequencer.
// CALC_SEQ_ZERO_FLAG_EN adds res_zero alongside res_data.
interface calc_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_data;

   logic [1:0]  calc_rd_addr;
   logic [1:0]  calc_we_addr;
   logic        calc_we;
   logic [3:0]  calc_immediate;
   logic [2:0]  calc_control;
   logic [3:0]  calc_rd_data;

   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_data;
`ifdef CALC_SEQ_ZERO_FLAG_EN
   logic        res_zero;

   modport master (
      output cmd_valid, cmd_data, res_ready, calc_rd_data,
      input  cmd_ready, calc_rd_addr, calc_we_addr, calc_we, calc_immediate, calc_control,
      input  res_valid, res_data, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_data, res_ready, calc_rd_data,
      output cmd_ready, calc_rd_addr, calc_we_addr, calc_we, calc_immediate, calc_control,
      output res_valid, res_data, res_zero
   );
`else
   modport master (
      output cmd_valid, cmd_data, res_ready, calc_rd_data,
      input  cmd_ready, calc_rd_addr, calc_we_addr, calc_we, calc_immediate, calc_control,
      input  res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_data, res_ready, calc_rd_data,
      output cmd_ready, calc_rd_addr, calc_we_addr, calc_we, calc_immediate, calc_control,
      output res_valid, res_data
   );
`endif
endinterface

// File: rtl/calc_sequencer.sv
// Instruction sequencer: FIFO-buffered commands drive the calculator, then read dst back.
// Optional CALC_SEQ_ZERO_FLAG_EN adds a registered res_zero flag.
module calc_sequencer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   calc_sequencer_if.slave bus,
   output logic            busy
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(SETTLE + 1);
   localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

   typedef enum logic [2:0] {StIdle, StSetup, StWrite, StReadback, StResp} state_e;

   state_e          state_q;
   logic [10:0]     fifo_mem [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic [CntW-1:0] settle_q;
   logic            push;
   logic            pop;
   logic [10:0]     head;

   logic [1:0]      rd_addr_q;
   logic [1:0]      we_addr_q;
   logic            we_q;
   logic [3:0]      imm_q;
   logic [2:0]      ctrl_q;
   logic            res_valid_q;
   logic [3:0]      res_data_q;

   // cmd_ready depends only on registered occupancy; a pop cannot free a slot the same cycle
   assign bus.cmd_ready = (count_q != Full);
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign pop           = (state_q == StIdle) && (count_q != '0);
   assign head          = fifo_mem[rd_ptr_q];
   assign busy          = (state_q != StIdle) || (count_q != '0);

   assign bus.calc_rd_addr   = rd_addr_q;
   assign bus.calc_we_addr   = we_addr_q;
   assign bus.calc_we        = we_q;
   assign bus.calc_immediate = imm_q;
   assign bus.calc_control   = ctrl_q;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_data       = res_data_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= bus.cmd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         settle_q    <= '0;
         rd_addr_q   <= '0;
         we_addr_q   <= '0;
         we_q        <= 1'b0;
         imm_q       <= '0;
         ctrl_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               we_q <= 1'b0;
               if (pop) begin
                  ctrl_q    <= head[10:8];
                  rd_addr_q <= head[7:6];
                  we_addr_q <= head[5:4];
                  imm_q     <= head[3:0];
                  settle_q  <= CntW'(SETTLE);
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (settle_q == '0) begin
                  we_q    <= 1'b1;
                  state_q <= StWrite;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            StWrite: begin
               // operand read of src is over once the strobe has fired; switch to dst
               we_q      <= 1'b0;
               rd_addr_q <= we_addr_q;
               settle_q  <= CntW'(SETTLE);
               state_q   <= StReadback;
            end
            StReadback: begin
               if (settle_q == '0) begin
                  res_data_q  <= bus.calc_rd_data;
                  res_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            StResp: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef CALC_SEQ_ZERO_FLAG_EN
   logic res_zero_q;

   assign bus.res_zero = res_zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_zero_q <= 1'b0;
      end else if (state_q == StReadback && settle_q == '0) begin
         res_zero_q <= (bus.calc_rd_data == 4'b0000);
      end
   end
`endif

endmodule
